io_port: RTL and testbench
==========================

// Module: io_port
// PURPOSE
//  Device-side end of the Basic Computer CPU I/O interface: holds INPR/FGI and OUTR/FGO.
//  Accepts bytes from an input device stream, raises FGI, and waits for the CPU to
//  execute INP; drains OUTR to an output device stream after a fixed print delay, then
//  raises FGO. Owns IEN and the interrupt flip-flop R. Sits beside data_unit; CPU drives
//  strobes, device side uses valid/ready.
// PARAMETERS
//  DW         8  width of INPR, OUTR and both device streams
//  OUT_DELAY  4  cycles OUTR is held before being offered on tx (0 = offer immediately)
// PORTS
//  clk       in   1   clock; all state updates on rising edge
//  reset     in   1   synchronous, active-high reset
//  inp_ack   in   1   CPU INP strobe: CPU reads inpr this cycle, clears FGI
//  out_ld    in   1   CPU OUT strobe: load out_dat into OUTR
//  out_dat   in   DW  AC value for OUT
//  ion       in   1   ION strobe: set IEN
//  iof       in   1   IOF strobe: clear IEN
//  intr_ack  in   1   interrupt cycle taken: clear R and IEN
//  err_clr   in   1   clear sticky err bits
//  inpr      out  DW  input register
//  fgi       out  1   input flag (SKI source)
//  fgo       out  1   output flag (SKO source)
//  ien       out  1   interrupt enable
//  irq       out  1   R flip-flop
//  err       out  2   sticky: [0] INP with fgi=0, [1] OUT with fgo=0
//  rx_dat    in   DW  input device byte
//  rx_valid  in   1   rx_dat valid
//  rx_ready  out  1   = ~fgi
//  tx_dat    out  DW  = outr
//  tx_valid  out  1   high only in state SEND
//  tx_ready  in   1   output device accepts tx_dat
// BEHAVIOUR
//  Reset: inpr=0, fgi=0, outr=0, fgo=1, ien=0, irq=0, err=0, state IDLE, tx_valid=0.
//   Reset overrides every other input, including mid-WAIT/SEND.
//  Input: rx transfer when rx_valid & rx_ready -> next edge inpr<=rx_dat, fgi<=1.
//   inp_ack & fgi -> fgi<=0; inpr holds its value. rx_ready is combinational from
//   registered fgi, so a byte is never accepted in the same cycle as inp_ack; the
//   earliest accept is the cycle after. inp_ack & ~fgi -> ignored, err[0]<=1.
//  Output FSM IDLE/WAIT/SEND; fgo=1 only in IDLE.
//   IDLE: out_ld -> outr<=out_dat, fgo<=0; go to WAIT with cnt=OUT_DELAY-1, or go
//    straight to SEND if OUT_DELAY=0.
//   WAIT: cnt decrements each cycle; when cnt==0 -> SEND. WAIT lasts exactly OUT_DELAY
//    cycles.
//   SEND: tx_valid=1; tx_dat stays stable until tx_ready. tx_ready -> fgo<=1, IDLE.
//   out_ld outside IDLE: outr unchanged, state unchanged, err[1]<=1.
//  Interrupt:
//   iof or intr_ack clears ien (priority over ion); otherwise ion sets ien.
//   intr_ack clears irq (priority); otherwise irq<=1 when ien & (fgi|fgo), using
//    registered values. Once set, irq holds until intr_ack or reset.
//  err: err_clr clears both bits; a new error set in the same cycle wins. Bits are
//   independent.
//  cnt width = clog2(OUT_DELAY+1), minimum 1.
// TESTING
//  1 reset -> fgi=0 fgo=1 rx_ready=1 tx_valid=0 irq=0 ien=0 err=0.
//  2 rx 0xA5 -> fgi=1, inpr=A5, rx_ready=0; 0x3C held pending until inp_ack; the
//    cycle after the ack, fgi=0 and 0x3C is accepted; inpr=3C, fgi=1.
//  3 out_ld 0x41 (OUT_DELAY=4) -> fgo=0; tx_valid=1 with tx_dat=41 exactly 4 cycles
//    after the load edge; tx_ready held low 3 cycles keeps tx_valid/tx_dat stable;
//    on tx_ready, fgo=1 at the next edge. Repeat with OUT_DELAY=0: tx_valid=1 on the
//    cycle after the load.
//  4 out_ld 0x7E during WAIT -> outr stays 41, err=2'b10; inp_ack with fgi=0 ->
//    err=2'b11; err_clr -> 00.
//  5 ion with fgo=1 -> ien=1 after edge 1, irq=1 after edge 2; intr_ack -> irq=0, ien=0;
//    ion & iof in the same cycle -> ien=0.
//  6 reset asserted mid-WAIT and mid-SEND -> after that edge: fgo=1, tx_valid=0,
//    outr=0, IDLE; no tx transfer occurs.

Source files
------------

// File: rtl/io_port.sv
// Device-side I/O port for the Basic Computer.
// Holds INPR/FGI, OUTR/FGO, IEN and the interrupt flip-flop R.
// The input side takes bytes on rx; the output side offers OUTR on tx after a fixed delay.
module io_port #(
    parameter int unsigned DW        = 8,
    parameter int unsigned OUT_DELAY = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inp_ack,
    input  logic          out_ld,
    input  logic [DW-1:0] out_dat,
    input  logic          ion,
    input  logic          iof,
    input  logic          intr_ack,
    input  logic          err_clr,
    output logic [DW-1:0] inpr,
    output logic          fgi,
    output logic          fgo,
    output logic          ien,
    output logic          irq,
    output logic [1:0]    err,
    input  logic [DW-1:0] rx_dat,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [DW-1:0] tx_dat,
    output logic          tx_valid,
    input  logic          tx_ready
);

    localparam int unsigned CW = (OUT_DELAY == 0) ? 1 : $clog2(OUT_DELAY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'((OUT_DELAY == 0) ? 0 : OUT_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [DW-1:0] outr;

    logic          out_load;
    logic          out_err;
    logic          tx_done;
    logic          rx_accept;
    logic          inp_err;

    // Output FSM state and delay counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output FSM next-state and counter logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (out_ld) begin
                    if (OUT_DELAY == 0) begin
                        state_nxt = S_SEND;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_SEND;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output FSM decodes: tx handshake, OUT acceptance and misuse
    always_comb begin
        tx_valid = 1'b0;
        out_load = 1'b0;
        out_err  = 1'b0;
        tx_done  = 1'b0;
        tx_valid = (state == S_SEND);
        out_load = out_ld & (state == S_IDLE);
        out_err  = out_ld & (state != S_IDLE);
        tx_done  = (state == S_SEND) & tx_ready;
    end

    // Input side handshake: a byte is only taken while FGI is clear
    assign rx_ready  = ~fgi;
    assign rx_accept = rx_valid & ~fgi;
    assign inp_err   = inp_ack & ~fgi;
    assign tx_dat    = outr;

    // Data registers and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            inpr <= '0;
            fgi  <= 1'b0;
            outr <= '0;
            fgo  <= 1'b1;
        end else begin
            if (rx_accept) begin
                inpr <= rx_dat;
                fgi  <= 1'b1;
            end else if (inp_ack) begin
                fgi  <= 1'b0;
            end
            if (out_load) begin
                outr <= out_dat;
                fgo  <= 1'b0;
            end else if (tx_done) begin
                fgo  <= 1'b1;
            end
        end
    end

    // Interrupt enable and R flip-flop; clears take priority over sets
    always_ff @(posedge clk) begin
        if (reset) begin
            ien <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (iof | intr_ack) begin
                ien <= 1'b0;
            end else if (ion) begin
                ien <= 1'b1;
            end
            if (intr_ack) begin
                irq <= 1'b0;
            end else if (ien & (fgi | fgo)) begin
                irq <= 1'b1;
            end
        end
    end

    // Sticky error bits; a fresh error wins over a clear in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 2'b00;
        end else begin
            err[0] <= inp_err | (err[0] & ~err_clr);
            err[1] <= out_err | (err[1] & ~err_clr);
        end
    end

endmodule

// File: tb/tb_io_port.sv
// Self-checking bench for io_port: directed table, hand sequences, random vs reference model.
module tb_io_port;

    localparam int unsigned DW = 8;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset, inp_ack, out_ld, ion, iof, intr_ack, err_clr;
    logic          rx_valid, tx_ready;
    logic [DW-1:0] out_dat, rx_dat;

    logic [DW-1:0] inpr, tx_dat;
    logic          fgi, fgo, ien, irq, rx_ready, tx_valid;
    logic [1:0]    err;

    logic [DW-1:0] inpr0, tx_dat0;
    logic          fgi0, fgo0, ien0, irq0, rx_ready0, tx_valid0;
    logic [1:0]    err0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    io_port #(.DW(DW), .OUT_DELAY(4)) dut (
        .clk(clk), .reset(reset), .inp_ack(inp_ack), .out_ld(out_ld), .out_dat(out_dat),
        .ion(ion), .iof(iof), .intr_ack(intr_ack), .err_clr(err_clr),
        .inpr(inpr), .fgi(fgi), .fgo(fgo), .ien(ien), .irq(irq), .err(err),
        .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_dat(tx_dat), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    io_port #(.DW(DW), .OUT_DELAY(0)) dut0 (
        .clk(clk), .reset(reset), .inp_ack(inp_ack), .out_ld(out_ld), .out_dat(out_dat),
        .ion(ion), .iof(iof), .intr_ack(intr_ack), .err_clr(err_clr),
        .inpr(inpr0), .fgi(fgi0), .fgo(fgo0), .ien(ien0), .irq(irq0), .err(err0),
        .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready0),
        .tx_dat(tx_dat0), .tx_valid(tx_valid0), .tx_ready(tx_ready)
    );

    // Reference model of the OUT_DELAY=4 instance: output side tracked as
    // "busy" plus the number of cycles elapsed since the load.
    logic [7:0] m_inpr, m_outr;
    logic       m_fgi, m_busy, m_ien, m_irq;
    logic [1:0] m_err;
    int         m_age;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic clr_inputs();
        reset = 1'b0; inp_ack = 1'b0; out_ld = 1'b0; out_dat = '0;
        ion = 1'b0; iof = 1'b0; intr_ack = 1'b0; err_clr = 1'b0;
        rx_valid = 1'b0; rx_dat = '0; tx_ready = 1'b0;
    endtask

    // One clock: advance the model from the applied inputs, then compare the DUT to it.
    task automatic tick();
        logic [7:0] n_inpr, n_outr;
        logic       n_fgi, n_busy, n_ien, n_irq, txv;
        logic [1:0] n_err;
        int         n_age;
        if (reset) begin
            n_inpr = 0; n_fgi = 0; n_outr = 0; n_busy = 0; n_age = 0;
            n_ien = 0; n_irq = 0; n_err = 0;
        end else begin
            n_inpr = m_inpr; n_fgi = m_fgi; n_outr = m_outr; n_busy = m_busy;
            n_age = m_age; n_ien = m_ien; n_irq = m_irq;
            n_err = err_clr ? 2'b00 : m_err;
            if (!m_fgi && rx_valid) begin
                n_inpr = rx_dat;
                n_fgi  = 1'b1;
            end
            if (inp_ack) begin
                if (m_fgi) n_fgi = 1'b0;
                else       n_err[0] = 1'b1;
            end
            txv = m_busy && (m_age >= D);
            if (!m_busy) begin
                if (out_ld) begin
                    n_outr = out_dat;
                    n_busy = 1'b1;
                    n_age  = 0;
                end
            end else begin
                if (out_ld) n_err[1] = 1'b1;
                if (txv && tx_ready) n_busy = 1'b0;
                else                 n_age = m_age + 1;
            end
            if (iof || intr_ack) n_ien = 1'b0;
            else if (ion)        n_ien = 1'b1;
            if (intr_ack)                        n_irq = 1'b0;
            else if (m_ien && (m_fgi || !m_busy)) n_irq = 1'b1;
        end
        @(posedge clk);
        #1;
        m_inpr = n_inpr; m_fgi = n_fgi; m_outr = n_outr; m_busy = n_busy;
        m_age = n_age; m_ien = n_ien; m_irq = n_irq; m_err = n_err;
        chk("m_inpr",     32'(inpr),     32'(m_inpr));
        chk("m_fgi",      32'(fgi),      32'(m_fgi));
        chk("m_fgo",      32'(fgo),      32'(!m_busy));
        chk("m_ien",      32'(ien),      32'(m_ien));
        chk("m_irq",      32'(irq),      32'(m_irq));
        chk("m_err",      32'(err),      32'(m_err));
        chk("m_rx_ready", 32'(rx_ready), 32'(!m_fgi));
        chk("m_tx_valid", 32'(tx_valid), 32'(m_busy && (m_age >= D)));
        chk("m_tx_dat",   32'(tx_dat),   32'(m_outr));
    endtask

    typedef struct {
        logic       rxv;
        logic [7:0] rxd;
        logic       ack;
        logic       ion;
        logic       iof;
        logic       iack;
        logic       eclr;
        logic       e_fgi;
        logic [7:0] e_inpr;
        logic [1:0] e_err;
        logic       e_ien;
        logic       e_irq;
    } vec_t;

    vec_t tbl [20];

    initial begin
        //         rxv  rxd    ack ion iof iack eclr  fgi inpr  err  ien irq
        tbl[0]  = '{1'b1, 8'hA5, 0, 0, 0, 0, 0,   1, 8'hA5, 2'b00, 0, 0};
        tbl[1]  = '{1'b1, 8'h3C, 0, 0, 0, 0, 0,   1, 8'hA5, 2'b00, 0, 0};
        tbl[2]  = '{1'b1, 8'h3C, 0, 0, 0, 0, 0,   1, 8'hA5, 2'b00, 0, 0};
        tbl[3]  = '{1'b1, 8'h3C, 1, 0, 0, 0, 0,   0, 8'hA5, 2'b00, 0, 0};
        tbl[4]  = '{1'b1, 8'h3C, 0, 0, 0, 0, 0,   1, 8'h3C, 2'b00, 0, 0};
        tbl[5]  = '{1'b0, 8'h00, 1, 0, 0, 0, 0,   0, 8'h3C, 2'b00, 0, 0};
        tbl[6]  = '{1'b0, 8'h00, 1, 0, 0, 0, 0,   0, 8'h3C, 2'b01, 0, 0};
        tbl[7]  = '{1'b0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h3C, 2'b00, 0, 0};
        tbl[8]  = '{1'b0, 8'h00, 1, 0, 0, 0, 1,   0, 8'h3C, 2'b01, 0, 0};
        tbl[9]  = '{1'b0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h3C, 2'b00, 0, 0};
        tbl[10] = '{1'b0, 8'h00, 0, 1, 0, 0, 0,   0, 8'h3C, 2'b00, 1, 0};
        tbl[11] = '{1'b0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h3C, 2'b00, 1, 1};
        tbl[12] = '{1'b0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h3C, 2'b00, 1, 1};
        tbl[13] = '{1'b0, 8'h00, 0, 0, 0, 1, 0,   0, 8'h3C, 2'b00, 0, 0};
        tbl[14] = '{1'b0, 8'h00, 0, 1, 1, 0, 0,   0, 8'h3C, 2'b00, 0, 0};
        tbl[15] = '{1'b0, 8'h00, 0, 1, 0, 1, 0,   0, 8'h3C, 2'b00, 0, 0};
        tbl[16] = '{1'b0, 8'h00, 0, 1, 0, 0, 0,   0, 8'h3C, 2'b00, 1, 0};
        tbl[17] = '{1'b0, 8'h00, 0, 0, 1, 0, 0,   0, 8'h3C, 2'b00, 0, 1};
        tbl[18] = '{1'b0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h3C, 2'b00, 0, 1};
        tbl[19] = '{1'b0, 8'h00, 0, 0, 0, 1, 0,   0, 8'h3C, 2'b00, 0, 0};

        clr_inputs();
        reset = 1'b1;
        tick();
        tick();
        clr_inputs();

        // Reset state
        chk("rst_fgi",      32'(fgi),      32'(0));
        chk("rst_fgo",      32'(fgo),      32'(1));
        chk("rst_rx_ready", 32'(rx_ready), 32'(1));
        chk("rst_tx_valid", 32'(tx_valid), 32'(0));
        chk("rst_irq",      32'(irq),      32'(0));
        chk("rst_ien",      32'(ien),      32'(0));
        chk("rst_err",      32'(err),      32'(0));
        chk("rst_inpr",     32'(inpr),     32'(0));
        chk("rst_tx_dat",   32'(tx_dat),   32'(0));

        // Input handshake, error bits and interrupt control from the table
        for (int i = 0; i < 20; i++) begin
            clr_inputs();
            rx_valid = tbl[i].rxv; rx_dat = tbl[i].rxd; inp_ack = tbl[i].ack;
            ion = tbl[i].ion; iof = tbl[i].iof; intr_ack = tbl[i].iack; err_clr = tbl[i].eclr;
            tick();
            chk($sformatf("tbl%0d_fgi", i),  32'(fgi),  32'(tbl[i].e_fgi));
            chk($sformatf("tbl%0d_inpr", i), 32'(inpr), 32'(tbl[i].e_inpr));
            chk($sformatf("tbl%0d_err", i),  32'(err),  32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_ien", i),  32'(ien),  32'(tbl[i].e_ien));
            chk($sformatf("tbl%0d_irq", i),  32'(irq),  32'(tbl[i].e_irq));
            chk($sformatf("tbl%0d_rdy", i),  32'(rx_ready), 32'(!tbl[i].e_fgi));
        end
        clr_inputs();

        // OUT with a 4-cycle print delay, misuse during WAIT, stall in SEND
        out_ld = 1'b1; out_dat = 8'h41;
        tick();
        clr_inputs();
        chk("out_fgo_low", 32'(fgo), 32'(0));
        chk("out_tx_v0",   32'(tx_valid), 32'(0));
        tick();
        chk("out_tx_v1", 32'(tx_valid), 32'(0));
        out_ld = 1'b1; out_dat = 8'h7E;
        tick();
        clr_inputs();
        chk("out_ld_wait_outr", 32'(tx_dat), 32'h41);
        chk("out_ld_wait_err",  32'(err),    32'(2'b10));
        chk("out_tx_v2",        32'(tx_valid), 32'(0));
        inp_ack = 1'b1;
        tick();
        clr_inputs();
        chk("inp_noflag_err", 32'(err), 32'(2'b11));
        chk("out_tx_v3",      32'(tx_valid), 32'(0));
        err_clr = 1'b1;
        tick();
        clr_inputs();
        chk("err_clr",     32'(err),      32'(0));
        chk("out_tx_v4",   32'(tx_valid), 32'(1));
        chk("out_tx_dat4", 32'(tx_dat),   32'h41);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_v", i),   32'(tx_valid), 32'(1));
            chk($sformatf("stall%0d_dat", i), 32'(tx_dat),   32'h41);
            chk($sformatf("stall%0d_fgo", i), 32'(fgo),      32'(0));
        end
        tx_ready = 1'b1;
        tick();
        clr_inputs();
        chk("tx_done_fgo", 32'(fgo),      32'(1));
        chk("tx_done_v",   32'(tx_valid), 32'(0));

        // Zero-delay instance: offered on the cycle after the load
        reset = 1'b1;
        tick();
        clr_inputs();
        out_ld = 1'b1; out_dat = 8'h5A;
        tick();
        clr_inputs();
        chk("d0_tx_valid", 32'(tx_valid0), 32'(1));
        chk("d0_tx_dat",   32'(tx_dat0),   32'h5A);
        chk("d0_fgo",      32'(fgo0),      32'(0));
        tx_ready = 1'b1;
        tick();
        clr_inputs();
        chk("d0_done_fgo", 32'(fgo0),      32'(1));
        chk("d0_done_v",   32'(tx_valid0), 32'(0));

        // Reset during WAIT
        reset = 1'b1;
        tick();
        clr_inputs();
        out_ld = 1'b1; out_dat = 8'h11;
        tick();
        clr_inputs();
        tick();
        reset = 1'b1;
        tick();
        clr_inputs();
        chk("rst_wait_fgo", 32'(fgo),      32'(1));
        chk("rst_wait_v",   32'(tx_valid), 32'(0));
        chk("rst_wait_dat", 32'(tx_dat),   32'(0));

        // Reset during SEND, with the device ready in the same cycle
        out_ld = 1'b1; out_dat = 8'h22;
        tick();
        clr_inputs();
        for (int i = 0; i < D; i++) tick();
        chk("pre_rst_send_v", 32'(tx_valid), 32'(1));
        reset = 1'b1; tx_ready = 1'b1;
        tick();
        clr_inputs();
        chk("rst_send_fgo", 32'(fgo),      32'(1));
        chk("rst_send_v",   32'(tx_valid), 32'(0));
        chk("rst_send_dat", 32'(tx_dat),   32'(0));
        tick();
        chk("post_rst_v", 32'(tx_valid), 32'(0));

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 99) == 0);
            rx_valid = ($urandom_range(0, 1) == 0);
            rx_dat   = 8'($urandom);
            inp_ack  = ($urandom_range(0, 3) == 0);
            out_ld   = ($urandom_range(0, 3) == 0);
            out_dat  = 8'($urandom);
            ion      = ($urandom_range(0, 5) == 0);
            iof      = ($urandom_range(0, 7) == 0);
            intr_ack = ($urandom_range(0, 7) == 0);
            err_clr  = ($urandom_range(0, 7) == 0);
            tx_ready = ($urandom_range(0, 1) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
